change_dispenser: RTL
=====================

# change_dispenser

Downstream of change processing, this block turns a completed transaction into physical hand-outs. It captures the issued-ticket strobe together with the BCD change amount and ticket quantity, then drives the ticket printer and the coin hopper. Tickets are issued first, then change coins in 10/5/1 denominations, each item with a four-phase req/ack handshake. It reports busy, done and a sticky fault to the display/supervisor logic.

## Interface
- ACK_TIMEOUT, 255: max cycles waited in any single handshake phase before fault
- CNT_W, 4: width of the per-denomination down-counters

- CLK  in  1  system clock, rising edge
- RD  in  1  reset, asynchronous, active-high
- START  in  1  one-cycle strobe from change processing (ticket issued)
- REST_IN  in  8  change amount, BCD: [7:4] tens, [3:0] units
- QUA_IN  in  2  tickets to issue, 0..3
- TKT_REQ  out  1  ticket printer request
- TKT_ACK  in  1  ticket printer acknowledge
- HOP_REQ  out  1  hopper request, one coin per handshake
- HOP_SEL  out  2  denomination while HOP_REQ high: 01=1, 10=5, 11=10
- HOP_ACK  in  1  hopper acknowledge
- BUSY  out  1  high in any state other than IDLE/FAULT
- DONE  out  1  one-cycle pulse on successful completion
- FAULT  out  1  sticky; cleared only by RD

## Operation
- States: IDLE, LOAD, TKT, C10, C5, C1, FIN, FAULT.
- IDLE: START=1 → LOAD. START in any other state is ignored; no queueing.
- LOAD: latch n_tkt=QUA_IN, n10=tens, n5=(units≥5), n1=units−5·n5. If either BCD digit >9 → FAULT, with nothing dispensed. Otherwise go to the first state whose count is non-zero, in the order TKT, C10, C5, C1. If all counts are zero → FIN.
- Dispensing states:
  - Assert the request (TKT_REQ, or HOP_REQ with HOP_SEL).
  - Hold it until ACK is sampled high, then drop it.
  - Wait for ACK to be sampled low, then decrement the count.
  - At zero, advance to the next non-zero state, else FIN.
- HOP_SEL is stable for the whole period HOP_REQ is high. It is 00 otherwise.
- FIN: DONE=1 for one cycle → IDLE.
- Timeout: every wait-for-ACK-high and wait-for-ACK-low phase has a counter that restarts at phase entry. Reaching ACK_TIMEOUT cycles → FAULT.
- FAULT: all requests low, BUSY=0. Held until RD.
- An ACK that arrives while no request is outstanding is ignored.

## Timing
- Reset values: TKT_REQ=0, HOP_REQ=0, HOP_SEL=00, BUSY=0, DONE=0, FAULT=0, state=IDLE, all counters 0.
- START sampled at edge k → LOAD during cycle k+1. The first request is high in cycle k+2 (registered outputs).
- A request drops in the cycle after ACK is sampled high. The next request may rise in the cycle after ACK is sampled low, giving a minimum of 4 cycles per item with a 1-cycle-latency responder.
- All outputs are registered; there are no combinational paths from ACK to REQ.
- RD mid-transaction returns to the reset values immediately. Partially dispensed amounts are lost by design.

## Structure
- Package ticket_pkg holds:
  - state enum
  - denomination codes SEL_1=01, SEL_5=10, SEL_10=11
  - BCD digit width 4
  - max quantity 3
- Sub-module hs_channel contains one four-phase req/ack engine with its timeout counter and ports go, done, timeout. It is instantiated once and shared: the top FSM selects which ACK feeds it and which REQ it drives.

## Test plan
- REST_IN=8'h17, QUA_IN=2: START → 2 TKT handshakes, then HOP_SEL sequence 11,10,01,01, then DONE pulse. No FAULT.
- REST_IN=8'h00, QUA_IN=0: START → no requests. DONE exactly 2 cycles after the START edge.
- REST_IN=8'h1A: START → FAULT=1 after LOAD, with no TKT_REQ/HOP_REQ ever asserted.
- Hopper never asserts ACK: HOP_REQ held ACK_TIMEOUT cycles → FAULT=1, HOP_REQ=0, BUSY=0. Stays until RD pulse, after which all outputs return to reset values.
- START re-pulsed during C10 with REST_IN=8'h20 → second START ignored; exactly 2 coins of SEL 11 issued, and one DONE.
- RD asserted while TKT_REQ=1 → TKT_REQ=0 asynchronously. A subsequent START with REST_IN=8'h05, QUA_IN=1 → 1 ticket, 1 coin SEL 10, DONE.

Source files
------------

// File: rtl/ticket_pkg.sv
// Shared types and constants for the change dispenser: FSM states, handshake
// phases, hopper denomination codes and the slot helpers used for sequencing.
package ticket_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TKT,
    ST_C10,
    ST_C5,
    ST_C1,
    ST_FIN,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_HI,
    PH_LO
  } phase_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_1    = 2'b01;
  localparam logic [1:0] SEL_5    = 2'b10;
  localparam logic [1:0] SEL_10   = 2'b11;

  localparam int BCD_W   = 4;
  localparam int MAX_QTY = 3;
  localparam int N_SLOT  = 4;

  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [BCD_W-1:0] BCD_FIVE = 4'd5;

  // Dispensing slots in issue order: 0=ticket, 1=ten, 2=five, 3=one.
  function automatic state_t slot_state(int s);
    case (s)
      0:       return ST_TKT;
      1:       return ST_C10;
      2:       return ST_C5;
      default: return ST_C1;
    endcase
  endfunction

  function automatic int state_slot(state_t st);
    case (st)
      ST_C10:  return 1;
      ST_C5:   return 2;
      ST_C1:   return 3;
      default: return 0;
    endcase
  endfunction

  function automatic state_t first_pending(logic [N_SLOT-1:0] nz);
    state_t st;
    st = ST_FIN;
    for (int i = N_SLOT - 1; i >= 0; i--) begin
      if (nz[i]) st = slot_state(i);
    end
    return st;
  endfunction

  function automatic logic [1:0] state_sel(state_t st);
    case (st)
      ST_C10:  return SEL_10;
      ST_C5:   return SEL_5;
      ST_C1:   return SEL_1;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hs_channel.sv
// One four-phase req/ack engine: waits for ack high, then ack low, with a
// per-phase timeout. The owner routes ack in and req out.
module hs_channel
  import ticket_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic ack,
  output logic accept,
  output logic done,
  output logic timeout
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  phase_t          phase_reg;
  logic   [TW-1:0] timer_reg;
  logic            stalled;

  always_comb begin
    accept  = (phase_reg == PH_HI) && ack;
    done    = (phase_reg == PH_LO) && !ack;
    stalled = ((phase_reg == PH_HI) && !ack) || ((phase_reg == PH_LO) && ack);
    timeout = stalled && (timer_reg == TW'(ACK_TIMEOUT - 1));
  end

  // done and go may coincide: the next item starts on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg <= PH_IDLE;
      timer_reg <= '0;
    end else begin
      case (phase_reg)
        PH_IDLE: begin
          timer_reg <= '0;
          if (go) phase_reg <= PH_HI;
        end
        PH_HI: begin
          if (accept) begin
            phase_reg <= PH_LO;
            timer_reg <= '0;
          end else if (timeout) begin
            phase_reg <= PH_IDLE;
            timer_reg <= '0;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        PH_LO: begin
          if (done) begin
            phase_reg <= go ? PH_HI : PH_IDLE;
            timer_reg <= '0;
          end else if (timeout) begin
            phase_reg <= PH_IDLE;
            timer_reg <= '0;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        default: begin
          phase_reg <= PH_IDLE;
          timer_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Turns a completed sale into ticket prints and 10/5/1 coin hand-outs through
// a single shared handshake engine; reports busy, done and a sticky fault.
module change_dispenser
  import ticket_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 4
) (
  input  logic       CLK,
  input  logic       RD,
  input  logic       START,
  input  logic [7:0] REST_IN,
  input  logic [1:0] QUA_IN,
  output logic       TKT_REQ,
  input  logic       TKT_ACK,
  output logic       HOP_REQ,
  output logic [1:0] HOP_SEL,
  input  logic       HOP_ACK,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAULT
);

  state_t state_reg, state_next;

  logic [7:0] rest_reg;
  logic [1:0] qua_reg;

  logic [N_SLOT-1:0][CNT_W-1:0] cnt_reg;
  logic [N_SLOT-1:0][CNT_W-1:0] load_cnt;
  logic [N_SLOT-1:0]            nz;

  logic [BCD_W-1:0] tens, units;
  logic             bcd_bad, has_five, load_en, dispensing;
  int               cur_slot;

  logic go, ch_ack, ch_accept, ch_done, ch_timeout;

  logic       tkt_req_reg, hop_req_reg, busy_reg, done_reg, fault_reg;
  logic       tkt_req_next, hop_req_next, busy_next, done_next, fault_next;
  logic [1:0] hop_sel_reg, hop_sel_next;

  always_comb begin
    tens     = rest_reg[7:4];
    units    = rest_reg[3:0];
    bcd_bad  = (tens > BCD_MAX) || (units > BCD_MAX);
    has_five = (units >= BCD_FIVE);
    load_cnt[0] = CNT_W'(qua_reg);
    load_cnt[1] = CNT_W'(tens);
    load_cnt[2] = CNT_W'(has_five);
    load_cnt[3] = CNT_W'(has_five ? units - BCD_FIVE : units);
    load_en     = (state_reg == ST_LOAD) && !bcd_bad;
    dispensing  = (state_reg == ST_TKT) || (state_reg == ST_C10) ||
                  (state_reg == ST_C5)  || (state_reg == ST_C1);
    cur_slot    = state_slot(state_reg);
  end

  always_comb begin
    ch_ack = 1'b0;
    if (state_reg == ST_TKT) ch_ack = TKT_ACK;
    else if (dispensing)     ch_ack = HOP_ACK;
  end

  hs_channel #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_channel (
    .clk    (CLK),
    .rst    (RD),
    .go     (go),
    .ack    (ch_ack),
    .accept (ch_accept),
    .done   (ch_done),
    .timeout(ch_timeout)
  );

  always_ff @(posedge CLK or posedge RD) begin
    if (RD) begin
      rest_reg <= '0;
      qua_reg  <= '0;
    end else if ((state_reg == ST_IDLE) && START) begin
      rest_reg <= REST_IN;
      qua_reg  <= QUA_IN;
    end
  end

  for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_cnt
    always_ff @(posedge CLK or posedge RD) begin
      if (RD)
        cnt_reg[gi] <= '0;
      else if (load_en)
        cnt_reg[gi] <= load_cnt[gi];
      else if (ch_done && (cur_slot == gi))
        cnt_reg[gi] <= cnt_reg[gi] - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RD) begin
    if (RD) begin
      state_reg   <= ST_IDLE;
      tkt_req_reg <= 1'b0;
      hop_req_reg <= 1'b0;
      hop_sel_reg <= SEL_NONE;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      fault_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tkt_req_reg <= tkt_req_next;
      hop_req_reg <= hop_req_next;
      hop_sel_reg <= hop_sel_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      fault_reg   <= fault_next;
    end
  end

  // Pending mask covers only the current slot (if more remain) and later ones.
  always_comb begin
    state_next = state_reg;
    go         = 1'b0;
    nz         = '0;
    case (state_reg)
      ST_IDLE: if (START) state_next = ST_LOAD;
      ST_LOAD: begin
        if (bcd_bad) begin
          state_next = ST_FAULT;
        end else begin
          for (int i = 0; i < N_SLOT; i++) nz[i] = (load_cnt[i] != '0);
          state_next = first_pending(nz);
          go         = (state_next != ST_FIN);
        end
      end
      ST_TKT, ST_C10, ST_C5, ST_C1: begin
        if (ch_timeout) begin
          state_next = ST_FAULT;
        end else if (ch_done) begin
          for (int i = 0; i < N_SLOT; i++) begin
            if (i > cur_slot)       nz[i] = (cnt_reg[i] != '0);
            else if (i == cur_slot) nz[i] = (cnt_reg[i] > CNT_W'(1));
          end
          state_next = first_pending(nz);
          go         = (state_next != ST_FIN);
        end
      end
      ST_FIN:   state_next = ST_IDLE;
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tkt_req_next = tkt_req_reg;
    hop_req_next = hop_req_reg;
    hop_sel_next = hop_sel_reg;
    if (go) begin
      tkt_req_next = (state_next == ST_TKT);
      hop_req_next = (state_next != ST_TKT);
      hop_sel_next = state_sel(state_next);
    end else if (ch_accept || ch_timeout) begin
      tkt_req_next = 1'b0;
      hop_req_next = 1'b0;
      hop_sel_next = SEL_NONE;
    end
    busy_next  = (state_next != ST_IDLE) && (state_next != ST_FAULT);
    done_next  = (state_next == ST_FIN);
    fault_next = (state_next == ST_FAULT);
  end

  assign TKT_REQ = tkt_req_reg;
  assign HOP_REQ = hop_req_reg;
  assign HOP_SEL = hop_sel_reg;
  assign BUSY    = busy_reg;
  assign DONE    = done_reg;
  assign FAULT   = fault_reg;

endmodule
